// File: rtl/mm_pkg.sv
// mm_pkg: shared types and defaults for the matrix-multiply sequencer.
// State encoding and the drain-length helper live here.
package mm_pkg;

  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 8;
  localparam int K_MAX_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic int drain_len(input int n);
    return 2 * n + 2;
  endfunction

  localparam int DRAIN_LEN = drain_len(N_DEF);

endpackage

// File: rtl/mm_skew.sv
// mm_skew: gated triangular delay line for one array edge.
// Lane i sees i+1 registers, so lane 0 lags the gate by one cycle.
module mm_skew #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          vld,
  input  logic [N*DW-1:0] din,
  output logic [N*DW-1:0] dout
);

  logic [N*DW-1:0] gated;

  assign gated = vld ? din : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [(i+1)*DW-1:0] sr;

    if (i == 0) begin : g_head
      // single-stage lane: capture the gated slice
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sr <= '0;
        else if (clr) sr <= '0;
        else          sr <= gated[DW-1:0];
      end
    end else begin : g_tail
      // multi-stage lane: shift toward the top slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sr <= '0;
        else if (clr) sr <= '0;
        else          sr <= {sr[i*DW-1:0],
                             gated[i*DW +: DW]};
      end
    end

    assign dout[i*DW +: DW] = sr[i*DW +: DW];
  end

endmodule

// File: rtl/mm_sched.sv
// mm_sched: clear/feed/drain/handshake sequencer for the
// NxN systolic MAC array.
module mm_sched
  import mm_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DW    = DW_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            cfg_err,
  output logic            a_rd_en,
  output logic            b_rd_en,
  output logic [KW-1:0]   a_rd_addr,
  output logic [KW-1:0]   b_rd_addr,
  input  logic [N*DW-1:0] a_rd_data,
  input  logic [N*DW-1:0] b_rd_data,
  output logic [N*DW-1:0] a_feed,
  output logic [N*DW-1:0] b_feed,
  output logic            array_en,
  output logic            array_clr_n,
  output logic            res_valid,
  input  logic            res_ack
);

  localparam int DLEN = drain_len(N);
  localparam int DCW  = $clog2(DLEN);
  localparam logic [KW-1:0]  KCAP  = KW'(K_MAX);
  localparam logic [DCW-1:0] DLOAD = DCW'(DLEN - 1);

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [KW-1:0]  klen_q, klen_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           err_q, err_d;
  logic           clr_q;
  logic           vld_q;
  logic           feeding;
  logic           skew_clr;

  // state, counters and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      klen_q  <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      klen_q  <= klen_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
      clr_q   <= (state_d != CLEAR);
      vld_q   <= feeding;
    end
  end

  // next-state and counter updates
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    klen_d  = klen_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = CLEAR;
            klen_d  = (k_len > KCAP) ? KCAP : k_len;
          end
        end
      end
      CLEAR: begin
        state_d = FEED;
        k_d     = '0;
      end
      FEED: begin
        if (k_q == klen_q - KW'(1)) begin
          state_d = DRAIN;
          dcnt_d  = DLOAD;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == '0) state_d = DONE;
        else dcnt_d = dcnt_q - DCW'(1);
      end
      DONE: begin
        if (res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign feeding     = (state_q == FEED);
  assign skew_clr    = (state_q == CLEAR);
  assign busy        = (state_q != IDLE);
  assign cfg_err     = err_q;
  assign a_rd_en     = feeding;
  assign b_rd_en     = feeding;
  assign a_rd_addr   = feeding ? k_q : '0;
  assign b_rd_addr   = feeding ? k_q : '0;
  assign array_en    = feeding | (state_q == DRAIN);
  assign res_valid   = (state_q == DONE);
  assign array_clr_n = rst_n & clr_q;

  mm_skew #(.N(N), .DW(DW)) u_skew_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (skew_clr),
    .vld   (vld_q),
    .din   (a_rd_data),
    .dout  (a_feed)
  );

  mm_skew #(.N(N), .DW(DW)) u_skew_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (skew_clr),
    .vld   (vld_q),
    .din   (b_rd_data),
    .dout  (b_feed)
  );

endmodule

// File: tb/tb_mm_sched.sv
// tb_mm_sched: directed bench for mm_sched with a behavioural
// MAC array and operand buffers hung off its ports.
module tb_mm_sched;

  localparam int N     = 4;
  localparam int N2    = 2;
  localparam int DW    = 8;
  localparam int K_MAX = 64;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int DEPTH = 2 ** KW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic res_ack = 1'b0;
  logic use2 = 1'b0;

  logic busy, cfg_err, a_rd_en, b_rd_en;
  logic [KW-1:0] a_rd_addr, b_rd_addr;
  logic [N*DW-1:0] a_rd_data = '0;
  logic [N*DW-1:0] b_rd_data = '0;
  logic [N*DW-1:0] a_feed, b_feed;
  logic array_en, array_clr_n, res_valid;

  logic start2, ack2;
  logic busy2, err2, ar2, br2, en2, clr2, rv2;
  logic [KW-1:0] aa2, ba2;
  logic [N2*DW-1:0] zero2 = '0;
  logic [N2*DW-1:0] af2, bf2;

  logic [N*DW-1:0] amem [DEPTH];
  logic [N*DW-1:0] bmem [DEPTH];

  logic [DW-1:0] ain [N][N];
  logic [DW-1:0] bin [N][N];
  logic [DW-1:0] fa  [N][N];
  logic [DW-1:0] fb  [N][N];
  int pp  [N][N];
  int acc [N][N];
  int expc [N][N];

  int n_cmp = 0;
  int n_bad = 0;

  assign start2 = start & use2;
  assign ack2   = res_ack & use2;

  always #5 clk = ~clk;

  mm_sched #(.N(N), .DW(DW), .K_MAX(K_MAX)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .a_rd_en     (a_rd_en),
    .b_rd_en     (b_rd_en),
    .a_rd_addr   (a_rd_addr),
    .b_rd_addr   (b_rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_data   (b_rd_data),
    .a_feed      (a_feed),
    .b_feed      (b_feed),
    .array_en    (array_en),
    .array_clr_n (array_clr_n),
    .res_valid   (res_valid),
    .res_ack     (res_ack)
  );

  mm_sched #(.N(N2), .DW(DW), .K_MAX(K_MAX)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .k_len       (k_len),
    .busy        (busy2),
    .cfg_err     (err2),
    .a_rd_en     (ar2),
    .b_rd_en     (br2),
    .a_rd_addr   (aa2),
    .b_rd_addr   (ba2),
    .a_rd_data   (zero2),
    .b_rd_data   (zero2),
    .a_feed      (af2),
    .b_feed      (bf2),
    .array_en    (en2),
    .array_clr_n (clr2),
    .res_valid   (rv2),
    .res_ack     (ack2)
  );

  // operand buffers, one-cycle read latency
  always_ff @(posedge clk) begin
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
  end

  // PE inputs: array edge or neighbour forwarding register
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ain[i][0] = a_feed[i*DW +: DW];
      bin[0][i] = b_feed[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        ain[i][j] = fa[i][j-1];
        bin[j][i] = fb[j-1][i];
      end
    end
  end

  // MAC array: forward, registered multiply, accumulate
  always_ff @(posedge clk or negedge array_clr_n) begin
    if (!array_clr_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          fa[i][j]  <= '0;
          fb[i][j]  <= '0;
          pp[i][j]  <= 0;
          acc[i][j] <= 0;
        end
    end else if (array_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          fa[i][j]  <= ain[i][j];
          fb[i][j]  <= bin[i][j];
          pp[i][j]  <= int'(ain[i][j]) * int'(bin[i][j]);
          acc[i][j] <= acc[i][j] + pp[i][j];
        end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < DEPTH; k++) begin
      amem[k] = '0;
      bmem[k] = '0;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) expc[i][j] = 0;
  endtask

  task automatic load_small();
    clear_mem();
    amem[0][0 +: DW]  = 8'd1;
    amem[0][DW +: DW] = 8'd3;
    amem[1][0 +: DW]  = 8'd2;
    amem[1][DW +: DW] = 8'd4;
    bmem[0][0 +: DW]  = 8'd5;
    bmem[0][DW +: DW] = 8'd6;
    bmem[1][0 +: DW]  = 8'd7;
    bmem[1][DW +: DW] = 8'd8;
    expc[0][0] = 19;
    expc[0][1] = 22;
    expc[1][0] = 43;
    expc[1][1] = 50;
  endtask

  task automatic load_ident();
    clear_mem();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        amem[k][i*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
        bmem[k][i*DW +: DW] = DW'(4 * k + i);
        expc[k][i] = 4 * k + i;
      end
  endtask

  task automatic load_full();
    clear_mem();
    for (int k = 0; k < K_MAX; k++) begin
      amem[k] = '1;
      bmem[k] = '1;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) expc[i][j] = 4161600;
  endtask

  task automatic check_c(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j),
              acc[i][j], expc[i][j]);
  endtask

  task automatic run_job(input int kl, input int kr,
                         input bit inj, input string tag);
    int first, first2, clr_n, rd_n, err_n, en_first, bad_a;
    first = -1; first2 = -1; clr_n = 0; rd_n = 0;
    err_n = 0; en_first = -1; bad_a = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(kl);
    for (int c = 0; c < 200 && first < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start   = inj && (c == kl + 4);
        res_ack = inj && (c == 3);
        if (c > 0) k_len = '0;
      end
      #1;
      if (res_valid && first < 0) first = c;
      if (rv2 && first2 < 0) first2 = c;
      if (!array_clr_n) clr_n++;
      if (cfg_err) err_n++;
      if (array_en && en_first < 0) en_first = c;
      if (a_rd_en || b_rd_en) begin
        if (!(a_rd_en && b_rd_en)) bad_a++;
        if (a_rd_addr != KW'(rd_n)) bad_a++;
        if (b_rd_addr != KW'(rd_n)) bad_a++;
        rd_n++;
      end
    end
    res_ack = 1'b0;
    start   = 1'b0;
    check({tag, "_rv_cycle"}, first, kr + 2 * N + 4);
    check({tag, "_clr_pulses"}, clr_n, 1);
    check({tag, "_reads"}, rd_n, kr);
    check({tag, "_addr_bad"}, bad_a, 0);
    check({tag, "_err"}, err_n, 0);
    check({tag, "_en_first"}, en_first, 2);
    if (use2) check({tag, "_rv_cycle_n2"}, first2, 10);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    res_ack = 1'b1;
    #1 check({tag, "_busy_pre_ack"}, busy, 1'b1);
    @(negedge clk);
    res_ack = 1'b0;
    #1;
    check({tag, "_busy_post_ack"}, busy, 1'b0);
    check({tag, "_rv_post_ack"}, res_valid, 1'b0);
  endtask

  initial begin
    int cnt_e, cnt_b, cnt_r;

    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_rd_en", {a_rd_en, b_rd_en}, 2'b00);
    check("rst_addr", {a_rd_addr, b_rd_addr}, '0);
    check("rst_feed", {a_feed, b_feed}, '0);
    check("rst_en", array_en, 1'b0);
    check("rst_clr_n", array_clr_n, 1'b0);
    check("rst_rv", res_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_clr_n", array_clr_n, 1'b1);

    @(negedge clk);
    start = 1'b1;
    k_len = '0;
    cnt_e = 0; cnt_b = 0; cnt_r = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start = 1'b0;
      end
      #1;
      if (cfg_err) cnt_e++;
      if (busy) cnt_b++;
      if (a_rd_en || b_rd_en) cnt_r++;
    end
    check("kzero_err_pulses", cnt_e, 1);
    check("kzero_busy", cnt_b, 0);
    check("kzero_reads", cnt_r, 0);

    load_small();
    use2 = 1'b1;
    run_job(2, 2, 1'b0, "small");
    check_c("small");
    do_ack("small");
    use2 = 1'b0;

    load_ident();
    run_job(4, 4, 1'b0, "ident");
    check_c("ident");
    repeat (4) @(negedge clk);
    #1;
    check("ident_rv_hold", res_valid, 1'b1);
    check("ident_en_done", array_en, 1'b0);
    check_c("ident_hold");
    do_ack("ident");

    load_full();
    run_job(64, 64, 1'b0, "full");
    check_c("full");
    do_ack("full");

    run_job(127, 64, 1'b0, "cap");
    check_c("cap");
    do_ack("cap");

    load_ident();
    run_job(4, 4, 1'b1, "inj");
    check_c("inj");
    do_ack("inj");

    @(negedge clk);
    start = 1'b1;
    k_len = KW'(4);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("mid_rd_en", a_rd_en, 1'b1);
    check("mid_a_feed", a_feed, 32'h0000_0001);
    #1 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_rd", {a_rd_en, b_rd_en}, 2'b00);
    check("mid_feed", {a_feed, b_feed}, '0);
    check("mid_en", array_en, 1'b0);
    check("mid_clr_n", array_clr_n, 1'b0);
    check("mid_acc00", acc[0][0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_r = 0; cnt_b = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (res_valid) cnt_r++;
      if (busy) cnt_b++;
    end
    check("mid_no_rv", cnt_r, 0);
    check("mid_idle", cnt_b, 0);

    run_job(4, 4, 1'b0, "after");
    check_c("after");
    do_ack("after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
